// File: rtl/peripheral_spram_burst_biu_if.sv
// Core BIU bus bundle between a bus master and the burst-capable SPRAM slave.
interface peripheral_spram_burst_biu_if #(
   parameter int XLEN = 64,
   parameter int PLEN = 64
);
   logic            biu_stb_i;
   logic            biu_stb_ack_o;
   logic            biu_d_ack_o;
   logic [PLEN-1:0] biu_adri_i;
   logic [PLEN-1:0] biu_adro_o;
   logic [2:0]      biu_size_i;
   logic [2:0]      biu_type_i;
   logic [2:0]      biu_prot_i;
   logic            biu_lock_i;
   logic            biu_we_i;
   logic [XLEN-1:0] biu_d_i;
   logic [XLEN-1:0] biu_q_o;
   logic            biu_ack_o;
   logic            biu_err_o;

   modport slave (
      input  biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_prot_i,
             biu_lock_i, biu_we_i, biu_d_i,
      output biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o
   );

   modport master (
      output biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_prot_i,
             biu_lock_i, biu_we_i, biu_d_i,
      input  biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o
   );
endinterface

// File: rtl/peripheral_spram_burst_biu.sv
// BIU slave over a single-port synchronous RAM: SINGLE/INCR/WRAP bursts, byte-lane
// writes, pipelined reads of RD_LATENCY cycles and an address/size error response.
module peripheral_spram_burst_biu #(
   parameter int              XLEN       = 64,
   parameter int              PLEN       = 64,
   parameter int              DEPTH      = 1024,
   parameter int              RD_LATENCY = 1,
   parameter logic [PLEN-1:0] MEM_BASE   = '0
) (
   input logic                         clk,
   input logic                         rst,
   peripheral_spram_burst_biu_if.slave biu
);
   localparam int BPW  = XLEN / 8;
   localparam int OFFW = $clog2(BPW);
   localparam int AW   = $clog2(DEPTH);
   localparam int PW   = PLEN + 1;
   localparam logic [PLEN:0]         MEM_LIMIT  = {1'b0, MEM_BASE} + PW'(DEPTH * BPW);
   localparam logic [RD_LATENCY-1:0] EARLY_MASK = {RD_LATENCY{1'b1}} >> 1;

   typedef enum logic [2:0] {IDLE, WBURST, RBURST, RDRAIN, ERR} state_t;

   function automatic logic [4:0] beats(input logic [2:0] ty);
      case (ty)
         3'd2, 3'd3: beats = 5'd4;
         3'd4, 3'd5: beats = 5'd8;
         3'd6, 3'd7: beats = 5'd16;
         default:    beats = 5'd1;
      endcase
   endfunction

   // WRAP types (even, non-zero) keep the upper address bits of the N*2^size block.
   function automatic logic [PLEN-1:0] next_addr(input logic [PLEN-1:0] a,
                                                 input logic [2:0] sz, input logic [2:0] ty);
      logic [PLEN-1:0] step, mask;
      step = PLEN'(1) << sz;
      mask = (PLEN'(beats(ty)) << sz) - PLEN'(1);
      if (!ty[0] && ty != 3'd0) next_addr = (a & ~mask) | ((a + step) & mask);
      else                      next_addr = a + step;
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [PLEN-1:0] a);
      logic [PLEN-1:0] off;
      off = a - MEM_BASE;
      word_idx = off[OFFW +: AW];
   endfunction

   state_t          state_reg, state_next;
   logic [PLEN-1:0] addr_reg, addr_next, adro_reg, adro_next;
   logic [2:0]      size_reg, size_next, type_reg, type_next;
   logic [4:0]      left_reg, left_next;
   logic            wr_ack_reg, wr_ack_next, d_ack_reg, d_ack_next;
   logic            err_reg, err_next, stb_ack_reg, stb_ack_next;

   logic            accept, acc_err;
   logic [PLEN:0]   acc_step, acc_span;
   logic            wr_en, rd_en;
   logic [PLEN-1:0] wr_addr, rd_addr;
   logic [2:0]      wr_size;
   logic [OFFW-1:0] wr_lane;
   logic [BPW-1:0]  wr_be;

   logic [XLEN-1:0]       mem [DEPTH];
   logic [RD_LATENCY-1:0] rd_vld;
   logic [XLEN-1:0]       rd_q   [RD_LATENCY];
   logic [PLEN-1:0]       rd_adr [RD_LATENCY];

   logic unused_ok;
   assign unused_ok = ^{biu.biu_prot_i, biu.biu_lock_i};

   // INCR4/8/16 must fit the whole burst; every other type only its first beat.
   always_comb begin
      acc_step = PW'(1) << biu.biu_size_i;
      acc_span = acc_step;
      if (biu.biu_type_i[0] && biu.biu_type_i != 3'd1)
         acc_span = PW'(beats(biu.biu_type_i)) << biu.biu_size_i;
      acc_err = (biu.biu_size_i > 3'(OFFW))
             || ((biu.biu_adri_i & (acc_step[PLEN-1:0] - PLEN'(1))) != '0)
             || (biu.biu_adri_i < MEM_BASE)
             || (({1'b0, biu.biu_adri_i} + acc_span) > MEM_LIMIT);
   end

   assign accept = biu.biu_stb_i && stb_ack_reg;

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      size_next   = size_reg;
      type_next   = type_reg;
      left_next   = left_reg;
      adro_next   = adro_reg;
      wr_ack_next = 1'b0;
      d_ack_next  = 1'b0;
      err_next    = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = addr_reg;
      wr_size     = size_reg;
      rd_en       = 1'b0;
      rd_addr     = addr_reg;
      case (state_reg)
         IDLE: if (accept) begin
            addr_next = next_addr(biu.biu_adri_i, biu.biu_size_i, biu.biu_type_i);
            size_next = biu.biu_size_i;
            type_next = biu.biu_type_i;
            left_next = beats(biu.biu_type_i) - 5'd1;
            if (acc_err) begin
               state_next = ERR;
               err_next   = 1'b1;
            end else if (biu.biu_we_i) begin
               state_next  = WBURST;
               wr_en       = 1'b1;
               wr_addr     = biu.biu_adri_i;
               wr_size     = biu.biu_size_i;
               wr_ack_next = 1'b1;
               adro_next   = biu.biu_adri_i;
               d_ack_next  = beats(biu.biu_type_i) > 5'd1;
            end else begin
               rd_en      = 1'b1;
               rd_addr    = biu.biu_adri_i;
               state_next = (beats(biu.biu_type_i) > 5'd1) ? RBURST : RDRAIN;
            end
         end
         WBURST: if (left_reg != 5'd0) begin
            wr_en       = 1'b1;
            wr_ack_next = 1'b1;
            adro_next   = addr_reg;
            d_ack_next  = left_reg > 5'd1;
            left_next   = left_reg - 5'd1;
            addr_next   = next_addr(addr_reg, size_reg, type_reg);
         end else begin
            state_next = IDLE;
         end
         RBURST: begin
            rd_en     = 1'b1;
            left_next = left_reg - 5'd1;
            addr_next = next_addr(addr_reg, size_reg, type_reg);
            if (left_reg == 5'd1) state_next = RDRAIN;
         end
         // Leave once only the final pipeline stage still holds a beat.
         RDRAIN: if ((rd_vld & EARLY_MASK) == '0) state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      stb_ack_next = (state_next == IDLE);
      if (!rst) begin
         wr_en = 1'b0;
         rd_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         size_reg    <= '0;
         type_reg    <= '0;
         left_reg    <= '0;
         adro_reg    <= '0;
         wr_ack_reg  <= 1'b0;
         d_ack_reg   <= 1'b0;
         err_reg     <= 1'b0;
         stb_ack_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         size_reg    <= size_next;
         type_reg    <= type_next;
         left_reg    <= left_next;
         adro_reg    <= adro_next;
         wr_ack_reg  <= wr_ack_next;
         d_ack_reg   <= d_ack_next;
         err_reg     <= err_next;
         stb_ack_reg <= stb_ack_next;
      end
   end

   // Write data is lane-aligned on biu_d_i; only the addressed lanes are stored.
   assign wr_lane = wr_addr[OFFW-1:0];
   genvar gi;
   generate
      for (gi = 0; gi < BPW; gi++) begin : g_be
         assign wr_be[gi] = (gi >= int'(wr_lane)) && (gi < int'(wr_lane) + (1 << wr_size));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BPW; b++)
            if (wr_be[b]) mem[word_idx(wr_addr)][b*8 +: 8] <= biu.biu_d_i[b*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_vld <= '0;
         for (int s = 0; s < RD_LATENCY; s++) begin
            rd_q[s]   <= '0;
            rd_adr[s] <= '0;
         end
      end else begin
         rd_vld[0] <= rd_en;
         if (rd_en) begin
            rd_q[0]   <= mem[word_idx(rd_addr)];
            rd_adr[0] <= rd_addr;
         end
         for (int s = 1; s < RD_LATENCY; s++) begin
            rd_vld[s] <= rd_vld[s-1];
            if (rd_vld[s-1]) begin
               rd_q[s]   <= rd_q[s-1];
               rd_adr[s] <= rd_adr[s-1];
            end
         end
      end
   end

   assign biu.biu_stb_ack_o = stb_ack_reg;
   assign biu.biu_d_ack_o   = d_ack_reg;
   assign biu.biu_err_o     = err_reg;
   assign biu.biu_ack_o     = wr_ack_reg | rd_vld[RD_LATENCY-1];
   assign biu.biu_adro_o    = rd_vld[RD_LATENCY-1] ? rd_adr[RD_LATENCY-1] : adro_reg;
   assign biu.biu_q_o       = rd_q[RD_LATENCY-1];
endmodule

// File: tb/tb_peripheral_spram_burst_biu.sv
// Directed + randomized bench for the burst SPRAM BIU against a byte-array memory model
// with per-cycle expectations of ack, d_ack, err, stb_ack, adro and q.
module tb_peripheral_spram_burst_biu;
   localparam int XLEN = 64, PLEN = 64, DEPTH = 64, LAT = 2;
   localparam int MBYTES = DEPTH * 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   peripheral_spram_burst_biu_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();

   peripheral_spram_burst_biu #(
      .XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH), .RD_LATENCY(LAT), .MEM_BASE('0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .biu(bus.slave)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  mem_m [MBYTES];
   logic [63:0] burst_d [16];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_word(input longint a);
      logic [63:0] w;
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = mem_m[(a / 8) * 8 + b];
      return w;
   endfunction

   function automatic int nbeats(input logic [2:0] ty);
      case (ty)
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         3'd6, 3'd7: return 16;
         default:    return 1;
      endcase
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 16; i++) burst_d[i] = {$urandom, $urandom};
   endtask

   // One complete transaction; expectations come from the beat list and memory model.
   task automatic txn(input logic we, input logic [63:0] addr, input logic [2:0] size,
                      input logic [2:0] ty);
      longint      a, s, n, span, blk, base;
      longint      beat_a [16];
      logic [63:0] exp_q [16];
      bit          err, wrap, exp_ack;
      int          last, guard, idx;
      a    = longint'(addr);
      n    = nbeats(ty);
      s    = longint'(1) << size;
      blk  = n * s;
      base = a - (a % blk);
      wrap = (ty == 3'd2 || ty == 3'd4 || ty == 3'd6);
      for (int i = 0; i < n; i++)
         beat_a[i] = wrap ? base + ((a - base + i * s) % blk) : a + i * s;
      span = (ty == 3'd3 || ty == 3'd5 || ty == 3'd7) ? blk : s;
      err  = (s > 8) || (a % s != 0) || (a + span > MBYTES);
      if (!err) begin
         for (int i = 0; i < n; i++) begin
            if (we) begin
               for (longint b = beat_a[i] % 8; b < beat_a[i] % 8 + s; b++)
                  mem_m[(beat_a[i] / 8) * 8 + b] = burst_d[i][b*8 +: 8];
            end else begin
               exp_q[i] = model_word(beat_a[i]);
            end
         end
      end
      guard = 0;
      while (bus.biu_stb_ack_o !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("stb_ack_ready", 64'(bus.biu_stb_ack_o), 64'd1);
      bus.biu_stb_i  = 1'b1;
      bus.biu_adri_i = addr;
      bus.biu_size_i = size;
      bus.biu_type_i = ty;
      bus.biu_we_i   = we;
      bus.biu_prot_i = 3'($urandom_range(0, 7));
      bus.biu_lock_i = 1'($urandom_range(0, 1));
      bus.biu_d_i    = burst_d[0];
      last = err ? 2 : (we ? int'(n) + 1 : int'(n) + LAT);
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (k == 1) bus.biu_stb_i = 1'b0;
         exp_ack = !err && (we ? (k <= n) : (k >= LAT && k <= n - 1 + LAT));
         check("ack",     64'(bus.biu_ack_o),     64'(exp_ack));
         check("d_ack",   64'(bus.biu_d_ack_o),   64'(!err && we && k <= n - 1));
         check("err",     64'(bus.biu_err_o),     64'(err && k == 1));
         check("stb_ack", 64'(bus.biu_stb_ack_o), 64'(k == last));
         if (exp_ack) begin
            idx = we ? k - 1 : k - LAT;
            check("adro", bus.biu_adro_o, 64'(beat_a[idx]));
            if (!we) check("q", bus.biu_q_o, exp_q[idx]);
         end
         if (we && k < n) bus.biu_d_i = burst_d[k];
      end
      $display("txn we=%0d addr=%h size=%0d type=%0d err=%0d beats=%0d",
               we, addr, size, ty, err, n);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] ra;
      logic [2:0]  rs, rt;
      bus.biu_stb_i  = 1'b1;
      bus.biu_adri_i = '0;
      bus.biu_size_i = 3'd3;
      bus.biu_type_i = 3'd0;
      bus.biu_prot_i = '0;
      bus.biu_lock_i = 1'b0;
      bus.biu_we_i   = 1'b1;
      bus.biu_d_i    = '1;

      // Reset held with a pending strobe: nothing may be accepted or acknowledged.
      repeat (3) begin
         @(negedge clk);
         check("rst_stb_ack", 64'(bus.biu_stb_ack_o), 64'd0);
         check("rst_ack",     64'(bus.biu_ack_o),     64'd0);
         check("rst_d_ack",   64'(bus.biu_d_ack_o),   64'd0);
         check("rst_err",     64'(bus.biu_err_o),     64'd0);
      end
      check("rst_q",    bus.biu_q_o,    64'd0);
      check("rst_adro", bus.biu_adro_o, 64'd0);
      rst = 1'b1;
      bus.biu_stb_i = 1'b0;
      @(negedge clk);
      check("post_rst_stb_ack", 64'(bus.biu_stb_ack_o), 64'd1);
      $display("txn reset released");

      // Preload whole RAM with INCR16 dword bursts.
      for (int r = 0; r < 4; r++) begin
         fill_random();
         txn(1'b1, 64'(r * 128), 3'd3, 3'd7);
      end

      burst_d[0] = 64'h1122334455667788;
      txn(1'b1, 64'h10, 3'd3, 3'd0);
      txn(1'b0, 64'h10, 3'd3, 3'd0);

      burst_d[0] = 64'hABAB_ABAB_ABAB_ABAB;
      txn(1'b1, 64'h13, 3'd0, 3'd0);
      txn(1'b0, 64'h10, 3'd3, 3'd0);
      check("byte_lane3", bus.biu_q_o, 64'h11223344AB667788);

      for (int i = 0; i < 4; i++) burst_d[i] = {2{32'(i + 1)}};
      txn(1'b1, 64'h0, 3'd2, 3'd3);
      txn(1'b0, 64'h0, 3'd2, 3'd3);
      txn(1'b0, 64'h8, 3'd2, 3'd2);

      // Error cases, then confirm the surrounding RAM is untouched.
      fill_random();
      txn(1'b1, 64'h4,   3'd3, 3'd0);
      txn(1'b1, 64'h1C8, 3'd3, 3'd5);
      txn(1'b1, 64'h20,  3'd4, 3'd0);
      txn(1'b0, 64'h0,   3'd3, 3'd7);
      txn(1'b0, 64'h180, 3'd3, 3'd7);

      for (int r = 0; r < 60; r++) begin
         fill_random();
         rs = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
         rt = 3'($urandom_range(0, 7));
         ra = 64'($urandom_range(0, MBYTES - 1)) & ~((64'd1 << rs) - 64'd1);
         if ($urandom_range(0, 7) == 0 && rs != 3'd0) ra = ra | 64'd1;
         txn(1'($urandom_range(0, 1)), ra, rs, rt);
      end

      // Reset in the middle of an INCR16 write: beats 0..2 land, the rest must not.
      fill_random();
      bus.biu_stb_i  = 1'b1;
      bus.biu_adri_i = 64'h100;
      bus.biu_size_i = 3'd3;
      bus.biu_type_i = 3'd7;
      bus.biu_we_i   = 1'b1;
      bus.biu_d_i    = burst_d[0];
      for (int i = 0; i < 3; i++)
         for (int b = 0; b < 8; b++) mem_m[256 + i * 8 + b] = burst_d[i][b*8 +: 8];
      @(negedge clk);
      bus.biu_stb_i = 1'b0;
      bus.biu_d_i   = burst_d[1];
      @(negedge clk);
      bus.biu_d_i = burst_d[2];
      @(negedge clk);
      bus.biu_d_i = burst_d[3];
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ack",     64'(bus.biu_ack_o),     64'd0);
      check("midrst_d_ack",   64'(bus.biu_d_ack_o),   64'd0);
      check("midrst_stb_ack", 64'(bus.biu_stb_ack_o), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ack2",     64'(bus.biu_ack_o),     64'd0);
      check("midrst_stb_ack2", 64'(bus.biu_stb_ack_o), 64'd1);
      $display("txn mid-burst reset at 0x100");

      for (int r = 0; r < 4; r++) txn(1'b0, 64'(r * 128), 3'd3, 3'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
